// File: rtl/lfsr_draw_arb_if.sv
// Requester/consumer side of the shared LFSR draw arbiter.
// master drives requests and seed loads; slave (the arbiter) returns grants and drawn values.
// All slave outputs are registered inside the arbiter.
interface lfsr_draw_arb_if;
  logic       seed_we;
  logic [8:0] seed;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       valid;
  logic [8:0] rnd;
  logic       busy;

  modport master (
    output seed_we, seed, req,
    input  gnt, valid, rnd, busy
  );

  modport slave (
    input  seed_we, seed, req,
    output gnt, valid, rnd, busy
  );
endinterface

// File: rtl/lfsr_draw_arb.sv
// Round-robin arbiter sharing one 9-bit Fibonacci LFSR between two requesters; owns seed loading.
// Latency: valid pulses STEPS+1 cycles after req is sampled in IDLE; one draw per STEPS+2 cycles max.
// No backpressure: req is a level, a granted draw always completes, valid is a single-cycle pulse.
module lfsr_draw_arb #(
  parameter int unsigned STEPS = 4  // shifts per draw, legal range 1..15
) (
  input  logic            clk,
  input  logic            rst_b,
  lfsr_draw_arb_if.slave  bus
);

  localparam logic [3:0] STEPS_C = 4'(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [8:0] lfsr;
  logic [3:0] cnt;
  logic       last;   // index of the requester served most recently
  logic       win;    // index of the requester currently being served

  logic       fb;
  logic [8:0] lfsr_step;
  logic       pick;

  // Next LFSR value after a single shift.
  assign fb        = lfsr[8] ^ lfsr[6] ^ lfsr[5] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0];
  assign lfsr_step = {lfsr[7:0], fb};

  // Winner selection: a lone request wins outright; on contention the one not served last wins.
  assign pick = (bus.req == 2'b11) ? ~last : (bus.req == 2'b10);

  // Sequencer: seed load / accept in IDLE, STEPS shifts in RUN, one valid cycle in DONE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      lfsr      <= 9'h001;
      cnt       <= 4'd0;
      last      <= 1'b1;
      win       <= 1'b0;
      bus.gnt   <= 2'b00;
      bus.valid <= 1'b0;
      bus.rnd   <= 9'h000;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.seed_we) begin
            // Seed wins over requests; zero would lock the LFSR, so it maps to 1.
            lfsr <= (bus.seed == 9'h000) ? 9'h001 : bus.seed;
          end else if (bus.req != 2'b00) begin
            win      <= pick;
            bus.gnt  <= pick ? 2'b10 : 2'b01;
            bus.busy <= 1'b1;
            cnt      <= STEPS_C;
            state    <= RUN;
          end
        end

        RUN: begin
          lfsr <= lfsr_step;
          cnt  <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Final shift: present its result registered alongside the DONE state.
            bus.valid <= 1'b1;
            bus.rnd   <= lfsr_step;
            state     <= DONE;
          end
        end

        DONE: begin
          bus.valid <= 1'b0;
          bus.gnt   <= 2'b00;
          bus.busy  <= 1'b0;
          last      <= win;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_draw_arb.sv
// Directed bench for lfsr_draw_arb with STEPS=4 and hand-computed LFSR sequences.
// Inputs are driven and outputs sampled on the falling edge of clk.
// From seed 1 the draws are 01C, 1C0, 004, 048; from seed 0AA the draw is 0A7.
module tb_lfsr_draw_arb;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  lfsr_draw_arb_if bus ();

  lfsr_draw_arb #(.STEPS(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue a one-cycle request then wait (bounded) for valid; lat counts falling edges from the request.
  task automatic draw(input logic [1:0] req_pat, output logic [8:0] r,
                      output logic [1:0] g, output int lat);
    r   = 9'h000;
    g   = 2'b00;
    lat = -1;
    bus.req = req_pat;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.req = 2'b00;
      if (bus.valid === 1'b1) begin
        r   = bus.rnd;
        g   = bus.gnt;
        lat = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.req     = 2'b00;
    bus.seed_we = 1'b0;
    bus.seed    = 9'h000;
    rst_b       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.gnt, bus.valid, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: gnt/valid/busy=%b required 0000", {bus.gnt, bus.valid, bus.busy});
    end
    checks++;
    if (bus.rnd !== 9'h000) begin
      errors++;
      $display("FAIL reset_rnd: rnd=%h required 000", bus.rnd);
    end
  endtask

  task automatic test_first_draw();
    int glen;
    int vcnt;
    int vpos;
    logic [8:0] r;
    glen = 0; vcnt = 0; vpos = -1; r = 9'h000;
    bus.req = 2'b01;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      bus.req = 2'b00;  // dropped while granted: draw must still complete
      if (i == 1) begin
        checks++;
        if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL first_accept: gnt=%b busy=%b required 01 1", bus.gnt, bus.busy);
        end
      end
      if (bus.gnt !== 2'b00) glen++;
      if (bus.valid === 1'b1) begin
        vcnt++;
        vpos = i;
        r = bus.rnd;
      end
    end
    checks++;
    if (glen != 5) begin
      errors++;
      $display("FAIL first_gnt_len: cycles=%0d required 5", glen);
    end
    checks++;
    if (vcnt != 1 || vpos != 5) begin
      errors++;
      $display("FAIL first_valid: count=%0d at=%0d required 1 at 5", vcnt, vpos);
    end
    checks++;
    if (r !== 9'h01C) begin
      errors++;
      $display("FAIL first_rnd: rnd=%h required 01C", r);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.rnd !== 9'h01C) begin
      errors++;
      $display("FAIL first_after: busy=%b rnd=%h required 0 01C", bus.busy, bus.rnd);
    end
  endtask

  task automatic test_second_draw();
    logic [8:0] r;
    logic [1:0] g;
    int lat;
    draw(2'b01, r, g, lat);
    checks++;
    if (r !== 9'h1C0 || g !== 2'b01 || lat != 5) begin
      errors++;
      $display("FAIL second_draw: rnd=%h gnt=%b lat=%0d required 1C0 01 5", r, g, lat);
    end
  endtask

  task automatic test_seed_zero();
    logic [8:0] r;
    logic [1:0] g;
    int lat;
    bus.seed_we = 1'b1;
    bus.seed    = 9'h000;
    @(negedge clk);
    bus.seed_we = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL seed_zero_idle: busy=%b gnt=%b required 0 00", bus.busy, bus.gnt);
    end
    draw(2'b01, r, g, lat);
    checks++;
    if (r !== 9'h01C || lat != 5) begin
      errors++;
      $display("FAIL seed_zero_rnd: rnd=%h lat=%0d required 01C 5", r, lat);
    end
  endtask

  task automatic test_seed_in_run();
    int vcnt;
    logic [8:0] r;
    vcnt = 0; r = 9'h000;
    bus.req = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.req = 2'b00;
      bus.seed_we = (i >= 1 && i <= 3);
      bus.seed    = 9'h0AA;
      if (bus.valid === 1'b1) begin
        vcnt++;
        r = bus.rnd;
      end
    end
    bus.seed_we = 1'b0;
    checks++;
    if (vcnt != 1 || r !== 9'h1C0) begin
      errors++;
      $display("FAIL seed_in_run: valids=%0d rnd=%h required 1 1C0", vcnt, r);
    end
  endtask

  task automatic test_seed_and_req();
    int lat;
    logic [8:0] r;
    lat = -1; r = 9'h000;
    bus.seed_we = 1'b1;
    bus.seed    = 9'h0AA;
    bus.req     = 2'b01;
    @(negedge clk);
    bus.seed_we = 1'b0;
    checks++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL seed_req_nogrant: gnt=%b busy=%b required 00 0", bus.gnt, bus.busy);
    end
    @(negedge clk);
    bus.req = 2'b00;
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL seed_req_grant: gnt=%b required 01", bus.gnt);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        lat = i;
        r = bus.rnd;
        break;
      end
    end
    checks++;
    if (lat != 4 || r !== 9'h0A7) begin
      errors++;
      $display("FAIL seed_req_rnd: rnd=%h at=%0d required 0A7 at 4", r, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    logic [8:0] exp_r [4];
    int idle, glen, vcnt, bound;
    logic [1:0] g;
    logic [8:0] r;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_r[0] = 9'h01C; exp_r[1] = 9'h1C0; exp_r[2] = 9'h004; exp_r[3] = 9'h048;
    apply_reset();
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      idle = 0; glen = 0; vcnt = 0; bound = 0; r = 9'h000;
      while (bus.gnt === 2'b00 && bound < 20) begin
        idle++; bound++;
        @(negedge clk);
      end
      g = bus.gnt;
      while (bus.gnt !== 2'b00 && bound < 40) begin
        glen++; bound++;
        if (bus.valid === 1'b1) begin
          vcnt++;
          r = bus.rnd;
        end
        @(negedge clk);
      end
      checks++;
      if (bound >= 40 || g !== exp_g[k] || glen != 5 || vcnt != 1 || r !== exp_r[k]) begin
        errors++;
        $display("FAIL b2b_draw%0d: gnt=%b len=%0d valids=%0d rnd=%h required %b 5 1 %h",
                 k, g, glen, vcnt, r, exp_g[k], exp_r[k]);
      end
      if (k > 0) begin
        checks++;
        if (idle != 1) begin
          errors++;
          $display("FAIL b2b_idle%0d: idle_cycles=%0d required 1", k, idle);
        end
      end
    end
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int vcnt;
    logic [8:0] r;
    logic [1:0] g;
    int lat;
    vcnt = 0;
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.valid, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset: gnt/valid/busy=%b required 0000", {bus.gnt, bus.valid, bus.busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL midrun_no_valid: valids=%0d required 0", vcnt);
    end
    draw(2'b01, r, g, lat);
    checks++;
    if (r !== 9'h01C || g !== 2'b01 || lat != 5) begin
      errors++;
      $display("FAIL midrun_next_draw: rnd=%h gnt=%b lat=%0d required 01C 01 5", r, g, lat);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_b       = 1'b0;
    bus.req     = 2'b00;
    bus.seed_we = 1'b0;
    bus.seed    = 9'h000;
    test_reset();
    test_first_draw();
    test_second_draw();
    test_seed_zero();
    test_seed_in_run();
    test_seed_and_req();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
